// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
//   Shared definitions for the data cache:
//     - state_t  : controller states (IDLE, COMPARE, WRITEBACK, ALLOCATE)
//     - WORD_BITS / ADDR_BITS : fixed 32-bit word and byte-address widths
//     - address-split helpers that derive offset/index/tag/word-select widths
//       from the LINE_SIZE and NUM_SETS parameters of the cache.
//   NUM_SETS is expected to be at least 2 so that the index field is non-empty.
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned ADDR_BITS = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  // Byte-offset width inside one line.
  function automatic int unsigned offset_bits(input int unsigned line_size);
    return $clog2(line_size);
  endfunction

  // Set-index width.
  function automatic int unsigned index_bits(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag width: whatever is left of the byte address.
  function automatic int unsigned tag_bits(input int unsigned line_size,
                                           input int unsigned num_sets);
    return ADDR_BITS - offset_bits(line_size) - index_bits(num_sets);
  endfunction

  // Word-select width; a one-word line still gets a 1-bit (always zero) select
  // so that no zero-width vector is ever declared.
  function automatic int unsigned word_sel_bits(input int unsigned line_size);
    return (offset_bits(line_size) > 2) ? offset_bits(line_size) - 2 : 1;
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// -----------------------------------------------------------------------------
// dcache_data_array
//   Tag / valid / dirty / line storage for a direct-mapped cache.
//   One shared index selects the set for both read and write.
//   Read is combinational; writes happen on the rising clock edge.
//
//   Ports
//     clk, reset   : clock, synchronous active-high reset (clears valid/dirty)
//     index        : set being read and written
//     rd_valid     : valid bit of the selected set
//     rd_dirty     : dirty bit of the selected set
//     rd_tag       : stored tag of the selected set
//     rd_line      : stored line of the selected set (word 0 in the low bits)
//     word_we      : write word_data into word word_sel and mark the set dirty
//     word_sel     : word position within the line for word_we
//     word_data    : store data
//     fill_we      : replace the whole line and tag; set valid, clear dirty
//     fill_tag     : tag for the filled line
//     fill_line    : line data from the backing memory
// -----------------------------------------------------------------------------
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter  int unsigned LINE_SIZE  = 16,
  parameter  int unsigned NUM_SETS   = 16,
  localparam int unsigned INDEX_BITS = index_bits(NUM_SETS),
  localparam int unsigned TAG_BITS   = tag_bits(LINE_SIZE, NUM_SETS),
  localparam int unsigned SEL_BITS   = word_sel_bits(LINE_SIZE),
  localparam int unsigned LINE_BITS  = LINE_SIZE * 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [LINE_BITS-1:0]  rd_line,
  input  logic                  word_we,
  input  logic [SEL_BITS-1:0]   word_sel,
  input  logic [WORD_BITS-1:0]  word_data,
  input  logic                  fill_we,
  input  logic [TAG_BITS-1:0]   fill_tag,
  input  logic [LINE_BITS-1:0]  fill_line
);

  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS];
  logic [LINE_BITS-1:0] data_mem [NUM_SETS];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_line  = data_mem[index];

  // Status bits: these alone decide whether stored contents mean anything.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // NOTE: tag and data storage carry no reset; they are never observed while
  // the matching valid bit is clear, so resetting them would only add muxes.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_line;
    end else if (word_we) begin
      data_mem[index][WORD_BITS*int'(word_sel) +: WORD_BITS] <= word_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//   Direct-mapped, write-back, write-allocate data cache sitting between the
//   MEM stage and a multi-cycle, line-wide backing memory.
//
//   Ports
//     clk, reset       : clock, synchronous active-high reset
//     is_input_valid   : request present from the MEM stage
//     addr             : byte address (addr[1:0] ignored, word access)
//     mem_rw           : 0 = load, 1 = store
//     din              : store data
//     is_ready         : cache is idle and can accept a request
//     is_output_valid  : one-cycle completion pulse per accepted request
//     dout             : load data, held between completions
//     is_hit           : qualified by is_output_valid; original access hit
//     mem_req          : backing-memory request, held until mem_ack
//     mem_we           : 1 = line write (evict), 0 = line read (fill)
//     mem_addr         : line-aligned backing-memory address
//     mem_wdata        : victim line
//     mem_ack          : one-cycle transfer-done pulse; mem_rdata valid with it
//     mem_rdata        : fill line
//   Optional (macro DCACHE_STATS_EN)
//     hit_count, miss_count : saturating per-request hit/miss counters
//
//   Latency: a hit completes two cycles after acceptance (COMPARE, then the
//   registered completion pulse). A miss loops back through COMPARE after the
//   fill, so it costs the hit latency plus the memory time plus one cycle.
// -----------------------------------------------------------------------------
module data_cache
  import dcache_pkg::*;
#(
  parameter  int unsigned LINE_SIZE = 16,
  parameter  int unsigned NUM_SETS  = 16,
  localparam int unsigned LINE_BITS = LINE_SIZE * 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_input_valid,
  input  logic [31:0]          addr,
  input  logic                 mem_rw,
  input  logic [31:0]          din,
  output logic                 is_ready,
  output logic                 is_output_valid,
  output logic [31:0]          dout,
  output logic                 is_hit,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [LINE_BITS-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int unsigned OFFSET_BITS = offset_bits(LINE_SIZE);
  localparam int unsigned INDEX_BITS  = index_bits(NUM_SETS);
  localparam int unsigned TAG_BITS    = tag_bits(LINE_SIZE, NUM_SETS);
  localparam int unsigned SEL_BITS    = word_sel_bits(LINE_SIZE);

  state_t state_q, state_d;

  // Latched request; the requester holds its inputs, but latching keeps the
  // cache independent of what the pipeline does with them meanwhile.
  logic [31:0] req_addr_q;
  logic        req_rw_q;
  logic [31:0] req_din_q;
  logic        miss_seen_q;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [SEL_BITS-1:0]   word_sel;
  logic                  unused_addr_bits;

  logic                  rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [LINE_BITS-1:0]  rd_line;
  logic [31:0]           rd_word;

  logic lookup_hit;
  logic accept;
  logic complete;
  logic word_we;
  logic fill_we;

  // ---------------------------------------------------------------- address
  assign req_tag          = req_addr_q[31 -: TAG_BITS];
  assign req_index        = req_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign unused_addr_bits = ^req_addr_q[1:0];

  generate
    if (OFFSET_BITS > 2) begin : g_word_sel
      assign word_sel = req_addr_q[OFFSET_BITS-1:2];
    end else begin : g_single_word
      assign word_sel = '0;
    end
  endgenerate

  // ---------------------------------------------------------------- storage
  dcache_data_array #(
    .LINE_SIZE (LINE_SIZE),
    .NUM_SETS  (NUM_SETS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .index     (req_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (req_din_q),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_line (mem_rdata)
  );

  assign rd_word    = rd_line[WORD_BITS*int'(word_sel) +: WORD_BITS];
  assign lookup_hit = rd_valid && (rd_tag == req_tag);
  assign is_ready   = (state_q == IDLE);
  assign accept     = is_input_valid && is_ready;
  // The victim is the line currently stored at the request's index; it stays
  // put for the whole WRITEBACK because nothing writes the array until mem_ack.
  assign mem_wdata  = rd_line;

  // --------------------------------------------------------- state register
  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers update from the same pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------- next state and controls
  // NOTE: every signal written here is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    word_we  = 1'b0;
    fill_we  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (lookup_hit) begin
          complete = 1'b1;
          word_we  = req_rw_q;
          state_d  = IDLE;
        end else if (rd_valid && rd_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end

      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {rd_tag, req_index, {OFFSET_BITS{1'b0}}};
        if (mem_ack) begin
          state_d = ALLOCATE;
        end
      end

      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, {OFFSET_BITS{1'b0}}};
        if (mem_ack) begin
          fill_we = 1'b1;
          state_d = COMPARE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------- request latch
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr_q <= addr;
      req_rw_q   <= mem_rw;
      req_din_q  <= din;
    end
  end

  // --------------------------------------------------- completion and dout
  // A second pass through COMPARE after a fill is still reported as a miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_seen_q     <= 1'b0;
      is_output_valid <= 1'b0;
      is_hit          <= 1'b0;
      dout            <= '0;
    end else begin
      is_output_valid <= complete;
      is_hit          <= complete && !miss_seen_q;
      if (complete && !req_rw_q) begin
        dout <= rd_word;
      end
      if (state_d == IDLE) begin
        miss_seen_q <= 1'b0;
      end else if (state_q == COMPARE && !lookup_hit) begin
        miss_seen_q <= 1'b1;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // ------------------------------------------------------ usage statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (complete) begin
      if (!miss_seen_q) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
//   Self-checking bench for data_cache (LINE_SIZE=16, NUM_SETS=16).
//   A behavioural cache model predicts each completion and each backing-memory
//   transaction; a bench-side backing memory answers mem_req with a
//   programmable ack delay. Directed scenarios add literal expectations.
//   Optional statistics ports are connected when DCACHE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_data_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_rw;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  data_cache #(.LINE_SIZE(16), .NUM_SETS(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_rw          (mem_rw),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ bookkeeping
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unwritten memory reads back a recognisable address-derived pattern.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // ------------------------------------------------------ behavioural model
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [23:0]  m_tag   [16];
  logic [31:0]  m_data  [16][4];
  logic [31:0]  ref_mem [logic [31:0]];
  logic [31:0]  m_last_dout = '0;
  int           m_hits = 0;
  int           m_misses = 0;

  bit           exp_hit_q   [$];
  logic [31:0]  exp_dout_q  [$];
  bit           exp_we_q    [$];
  logic [31:0]  exp_addr_q  [$];
  logic [127:0] exp_wdata_q [$];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic model_access(input logic [31:0] a, input bit rw,
                              input logic [31:0] d);
    int unsigned  set = a[7:4];
    int unsigned  w   = a[3:2];
    logic [23:0]  tag = a[31:8];
    logic [31:0]  base;
    logic [127:0] line;
    bit           hit = m_valid[set] && (m_tag[set] == tag);
    if (!hit) begin
      if (m_valid[set] && m_dirty[set]) begin
        base = {m_tag[set], set[3:0], 4'h0};
        for (int i = 0; i < 4; i++) begin
          line[32*i +: 32]   = m_data[set][i];
          ref_mem[base + 4*i] = m_data[set][i];
        end
        exp_we_q.push_back(1'b1);
        exp_addr_q.push_back(base);
        exp_wdata_q.push_back(line);
      end
      base = {tag, set[3:0], 4'h0};
      exp_we_q.push_back(1'b0);
      exp_addr_q.push_back(base);
      exp_wdata_q.push_back('0);
      for (int i = 0; i < 4; i++) m_data[set][i] = ref_rd(base + 4*i);
      m_valid[set] = 1'b1;
      m_dirty[set] = 1'b0;
      m_tag[set]   = tag;
      m_misses++;
    end else begin
      m_hits++;
    end
    if (rw) begin
      m_data[set][w] = d;
      m_dirty[set]   = 1'b1;
    end else begin
      m_last_dout = m_data[set][w];
    end
    exp_hit_q.push_back(hit);
    exp_dout_q.push_back(m_last_dout);
  endtask

  bit busy = 1'b0;

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    m_last_dout = '0;
    exp_hit_q.delete();
    exp_dout_q.delete();
    exp_we_q.delete();
    exp_addr_q.delete();
    exp_wdata_q.delete();
    busy = 1'b0;
  endtask

  // --------------------------------------------------------- compare process
  int          done_cnt = 0;
  int          out_cyc = 0;
  int          accept_cyc = 0;
  logic        last_hit;
  logic [31:0] last_dout;

  always @(negedge clk) begin
    if (!reset) begin
      if (is_output_valid) begin
        if (exp_hit_q.size() == 0) begin
          check("spurious_output_valid", 1'b1, 1'b0);
        end else begin
          check("is_hit", is_hit, exp_hit_q.pop_front());
          check("dout", dout, exp_dout_q.pop_front());
        end
        last_hit  = is_hit;
        last_dout = dout;
        out_cyc   = cyc;
        done_cnt++;
        busy = 1'b0;
      end
      check("is_ready", is_ready, !busy);
      if (!busy) check("mem_req_idle", mem_req, 1'b0);
    end
  end

  // ---------------------------------------------------------- backing memory
  logic [31:0]  bmem [logic [31:0]];
  int           ack_delay = 0;
  int           wait_cnt = 0;
  logic [31:0]  hold_addr;
  logic         hold_we;
  int           wb_cnt = 0;
  int           fill_cnt = 0;
  logic [31:0]  last_wb_addr, last_fill_addr;
  logic [127:0] last_wb_data;

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) begin
          hold_addr = mem_addr;
          hold_we   = mem_we;
          if (exp_addr_q.size() == 0) begin
            check("unexpected_mem_req", 1'b1, 1'b0);
          end else begin
            check("mem_we", mem_we, exp_we_q.pop_front());
            check("mem_addr", mem_addr, exp_addr_q.pop_front());
            if (mem_we) check("mem_wdata", mem_wdata, exp_wdata_q.pop_front());
            else        void'(exp_wdata_q.pop_front());
          end
        end else begin
          check("mem_addr_stable", mem_addr, hold_addr);
          check("mem_we_stable", mem_we, hold_we);
          check("is_ready_during_mem", is_ready, 1'b0);
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            for (int i = 0; i < 4; i++) bmem[mem_addr + 4*i] = mem_wdata[32*i +: 32];
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
            wb_cnt++;
          end else begin
            for (int i = 0; i < 4; i++) mem_rdata[32*i +: 32] = bmem_rd(mem_addr + 4*i);
            last_fill_addr = mem_addr;
            fill_cnt++;
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic issue_req(input logic [31:0] a, input bit rw,
                           input logic [31:0] d);
    @(negedge clk);
    addr           = a;
    mem_rw         = rw;
    din            = d;
    is_input_valid = 1'b1;
    @(posedge clk);
    accept_cyc = cyc;
    busy       = 1'b1;
    model_access(a, rw, d);
    #1 is_input_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int start = done_cnt;
    for (int i = 0; i < 200 && done_cnt == start; i++) @(posedge clk);
    check("completion_timeout", done_cnt != start, 1'b1);
    lat = out_cyc - accept_cyc;
  endtask

  task automatic access(input logic [31:0] a, input bit rw, input logic [31:0] d,
                        output int lat);
    issue_req(a, rw, d);
    wait_done(lat);
  endtask

  // -------------------------------------------------------------- scenarios
  initial begin
    int lat;
    int n_txn;
    reset          = 1'b1;
    is_input_valid = 1'b0;
    addr           = '0;
    mem_rw         = 1'b0;
    din            = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_is_ready", is_ready, 1'b1);
    check("rst_output_valid", is_output_valid, 1'b0);
    check("rst_is_hit", is_hit, 1'b0);
    check("rst_dout", dout, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;

    // 1: cold load, clean allocate of line 0x40
    access(32'h40, 1'b0, '0, lat);
    check("t1_latency", lat, 4);
    check("t1_is_hit", last_hit, 1'b0);
    check("t1_dout", last_dout, 32'hC0DE_0040);
    check("t1_fill_addr", last_fill_addr, 32'h40);

    // 2: hit in the freshly filled line, no memory traffic
    n_txn = wb_cnt + fill_cnt;
    access(32'h44, 1'b0, '0, lat);
    check("t2_latency", lat, 2);
    check("t2_is_hit", last_hit, 1'b1);
    check("t2_dout", last_dout, 32'hC0DE_0044);
    check("t2_no_mem_txn", wb_cnt + fill_cnt, n_txn);

    // 3: dirty the line, then conflict-miss forces writeback then allocate
    access(32'h48, 1'b1, 32'hDEAD_BEEF, lat);
    check("t3_store_latency", lat, 2);
    check("t3_store_hit", last_hit, 1'b1);
    check("t3_store_dout_held", last_dout, 32'hC0DE_0044);
    access(32'h140, 1'b0, '0, lat);
    check("t3_latency", lat, 5);
    check("t3_is_hit", last_hit, 1'b0);
    check("t3_dout", last_dout, 32'hC0DE_0140);
    check("t3_wb_addr", last_wb_addr, 32'h40);
    check("t3_wb_word2", last_wb_data[95:64], 32'hDEAD_BEEF);
    check("t3_fill_addr", last_fill_addr, 32'h140);
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    check("t6_hit_count", hit_count, 32'd2);
    check("t6_miss_count", miss_count, 32'd2);
`endif

    // written-back word comes home; word select across the line
    access(32'h48, 1'b0, '0, lat);
    check("wb_roundtrip_dout", last_dout, 32'hDEAD_BEEF);
    check("wb_roundtrip_miss", last_hit, 1'b0);
    access(32'h4C, 1'b1, 32'h1234_5678, lat);
    access(32'h4C, 1'b0, '0, lat);
    check("store_load_dout", last_dout, 32'h1234_5678);
    access(32'h40, 1'b0, '0, lat);
    check("word0_dout", last_dout, 32'hC0DE_0040);

    // 4: slow memory, ack 5 cycles after mem_req rises
    ack_delay = 5;
    access(32'h200, 1'b0, '0, lat);
    check("t4_latency", lat, 9);
    check("t4_is_hit", last_hit, 1'b0);
    check("t4_dout", last_dout, 32'hC0DE_0200);

    // 5: reset while a fill is outstanding
    ack_delay = 20;
    issue_req(32'h300, 1'b0, '0);
    for (int i = 0; i < 20 && !(mem_req && !mem_we); i++) @(negedge clk);
    check("t5_alloc_seen", mem_req && !mem_we, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("t5_mem_req_drop", mem_req, 1'b0);
    check("t5_is_ready", is_ready, 1'b1);
    check("t5_output_valid", is_output_valid, 1'b0);
    check("t5_dout_cleared", dout, 32'h0);
    reset = 1'b0;
    ack_delay = 0;
    access(32'h300, 1'b0, '0, lat);
    check("t5_reload_miss", last_hit, 1'b0);
    check("t5_reload_dout", last_dout, 32'hC0DE_0300);
    // dirty store to 0x4C was discarded by reset; 0x48 was already written back
    access(32'h4C, 1'b0, '0, lat);
    check("t5_discard_dout", last_dout, 32'hC0DE_004C);
    access(32'h48, 1'b0, '0, lat);
    check("t5_kept_dout", last_dout, 32'hDEAD_BEEF);
    check("model_all_consumed", exp_hit_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
